fod_spi_regfile: RTL
====================

Name: fod_spi_regfile

Overview:
- SPI slave plus register bank that produces the full FOD control word set (FCW, phase-calibration, INL-calibration, sync/enable controls) for the FOD digital controller. It replaces behavioural control drivers with a programmable register path.
- SPI pins are oversampled in the system clock domain.
- Register reset values equal the FOD bring-up defaults, so the FOD runs unprogrammed, held in soft reset.

Parameters:
- WI, 6, integer width of FCW_FOD.
- WF, 16, fractional width of FCW_FOD.
- SYNC_STAGES, 2, synchronizer depth on SCLK/CS_N/MOSI (minimum 2).

Ports:
- CLK  in  1  system clock; must be at least 4x SCLK frequency.
- RST  in  1  asynchronous active-high reset.
- SCLK  in  1  SPI clock, mode 0.
- CS_N  in  1  SPI chip select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial read data; 0 when not driving.
- NARST  out  1  FOD soft reset, active low (CTRL[10]).
- FCW_FOD  out  WI+WF  committed frequency control word.
- PCALI_EN, FREQ_C_EN, FREQ_C_MODE, RT_EN, DTCCALI_EN, OFSTCALI_EN, SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP  out  1 each  CTRL[0..9], in that order.
- FREQ_C_KS  out  5  and PCALI_KS out 5, PCALI_FREQDOWN out 3.
- PHASE_CTRL  out  10  and PSEG out 2, CALIORDER out 2.
- KB, KC, KD  out  5 each  two's-complement gains.
- KDTCB_INIT, KDTCC_INIT, KDTCD_INIT  out  10 each.

Behaviour:
- Frame: 24 bits, MSB first. Bit23 = W (1 write, 0 read). Bits22:16 = ADDR. Bits15:0 = DATA. MOSI is sampled on SCLK rise; MISO changes on SCLK fall.
- Sync and edges: SCLK, CS_N and MOSI pass through SYNC_STAGES flops. An edge is detected between the last sync stage and one extra flop. A bit shifts in on the CLK cycle the rise is detected.
- Register map. Reset values in brackets; unused bits read 0.
  - 0x00 FCW_LO[15:0] staging [0xC000].
  - 0x01 FCW_HI[5:0] staging [0x0004]. A write to 0x01 also commits {HI,LO} to FCW_FOD atomically. Writing 0x00 alone never changes FCW_FOD. Reset FCW_FOD = 0x04C000 (4.75).
  - 0x02 CTRL[10:0] [0x0189].
  - 0x03 FREQ_C_KS[4:0], PCALI_KS[9:5], PCALI_FREQDOWN[12:10] [0x0100].
  - 0x04 PHASE_CTRL[9:0], PSEG[11:10], CALIORDER[13:12] [0x3C00].
  - 0x05 KB[4:0], KC[9:5], KD[14:10] [0x6FA0].
  - 0x06 KDTCB_INIT [0x0186]; 0x07 KDTCC_INIT [0x00C3]; 0x08 KDTCD_INIT [0x0000].
  - Other addresses: writes ignored, reads return 0.
- FSM:
  - IDLE: on CS_N fall go to CMD, clearing the bit counter.
  - CMD: after 8 bits, latch W/ADDR. For a read, load the read shadow from the addressed register (staging value for 0x00/0x01), then go to DATA.
  - DATA: after 16 more bits go to DONE. For a write, the register updates on the CLK edge after the 24th bit's shift cycle.
  - DONE: further SCLK edges are ignored. Go to IDLE on CS_N rise.
  - A CS_N rise in CMD or DATA aborts the frame to IDLE with no register change.
- MISO during read DATA: the shadow MSB is presented after the 8th rise and shifts on each detected fall. It is 0 in all other states.
- Reset:
  - RST asserted at any time, including mid-frame, asynchronously loads all reset values, clears the shifter and sets MISO=0.
  - If CS_N is low when RST releases, the FSM enters DONE and waits for CS_N high, so no partial frame is accepted.
- Bit counter is 5 bits and saturates in DONE; it never wraps.

Test Plan:
- Reset: RST pulse, no SPI -> FCW_FOD=0x04C000, NARST=0, PCALI_EN=RT_EN=DSM_SYNC_NRST_EN=NCO_SYNC_NRST_EN=1, PCALI_KS=8, PSEG=3, CALIORDER=3, KC=5'h1D, KD=5'h1B, KDTCB_INIT=390, KDTCC_INIT=195.
- FCW commit:
  - Write 0x00=0x8000 -> FCW_FOD unchanged.
  - Then write 0x01=0x0005 -> FCW_FOD=0x058000 within 1 CLK of the 24th bit.
  - Read 0x00 -> MISO returns 0x8000.
- Control write: write 0x02=0x0410 -> NARST=1, DTCCALI_EN=1, all other CTRL outputs 0. Read 0x02 returns 0x0410.
- Abort: CS_N rises after 20 bits of a write 0x06=0x03FF -> KDTCB_INIT stays 390. A following full frame to 0x06 writes normally.
- Invalid address: write 0x7F=0xFFFF -> no output changes; read 0x7F -> MISO all 0.
- Reset mid-frame: RST pulse at bit 12 with CS_N held low, remaining bits clocked -> all defaults, no write. The next frame after a CS_N high/low cycle is accepted.

Source files
------------

// File: rtl/fod_spi_regfile.sv
// SPI slave (mode 0, 24-bit frames) feeding the FOD control register bank.
// SPI pins are oversampled in the CLK domain. Reset values are the FOD bring-up
// defaults, so the FOD runs unprogrammed while held in soft reset (NARST=0).
module fod_spi_regfile #(
  parameter int WI          = 6,
  parameter int WF          = 16,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCLK,
  input  logic             CS_N,
  input  logic             MOSI,
  output logic             MISO,
  output logic             NARST,
  output logic [WI+WF-1:0] FCW_FOD,
  output logic             PCALI_EN,
  output logic             FREQ_C_EN,
  output logic             FREQ_C_MODE,
  output logic             RT_EN,
  output logic             DTCCALI_EN,
  output logic             OFSTCALI_EN,
  output logic             SYS_EN,
  output logic             DSM_SYNC_NRST_EN,
  output logic             NCO_SYNC_NRST_EN,
  output logic             FREQ_HOP,
  output logic [4:0]       FREQ_C_KS,
  output logic [4:0]       PCALI_KS,
  output logic [2:0]       PCALI_FREQDOWN,
  output logic [9:0]       PHASE_CTRL,
  output logic [1:0]       PSEG,
  output logic [1:0]       CALIORDER,
  output logic [4:0]       KB,
  output logic [4:0]       KC,
  output logic [4:0]       KD,
  output logic [9:0]       KDTCB_INIT,
  output logic [9:0]       KDTCC_INIT,
  output logic [9:0]       KDTCD_INIT
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_e;

  localparam logic [WF-1:0] FCW_LO_RST = WF'(16'hC000);
  localparam logic [WI-1:0] FCW_HI_RST = WI'(16'h0004);

  // Synchronizers plus one extra flop each for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_last_q, cs_last_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        shift_en, cmd_done, frame_done, shadow_shift;
  logic [23:0] shift_q;
  logic        wr_q, wr_pend_q;
  logic [6:0]  addr_q, cmd_addr;
  logic [15:0] shadow_q, rd_data, wdata;

  logic [WF-1:0]    fcw_lo_q;
  logic [WI-1:0]    fcw_hi_q;
  logic [WI+WF-1:0] fcw_q;
  logic [10:0]      ctrl_q;
  logic [12:0]      cfg3_q;
  logic [13:0]      cfg4_q;
  logic [14:0]      cfg5_q;
  logic [9:0]       kdtcb_q, kdtcc_q, kdtcd_q;

  // Pin synchronizers. The CS_N chain resets to 0 (selected) and the FSM resets
  // to DONE, so a frame already in progress at reset release is never accepted.
  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_last_q <= 1'b0;
      cs_last_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_last_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_last_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_last_q;
  assign sclk_fall = ~sclk_s & sclk_last_q;
  assign cs_rise   = cs_s & ~cs_last_q;
  assign cs_fall   = ~cs_s & cs_last_q;

  // FSM state and bit counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_DONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and per-cycle strobes for the frame datapath.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_en     = 1'b0;
    cmd_done     = 1'b0;
    frame_done   = 1'b0;
    shadow_shift = 1'b0;
    unique case (state_q)
      S_IDLE: if (cs_fall) begin
        state_d = S_CMD;
        cnt_d   = '0;
      end
      S_CMD: begin
        if (cs_rise) state_d = S_IDLE;
        else if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cmd_done = 1'b1;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cs_rise) state_d = S_IDLE;
        else begin
          if (sclk_rise) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              frame_done = 1'b1;
              state_d    = S_DONE;
            end
          end
          // The fall right after the command byte keeps the MSB in place so
          // the master samples it on the 9th rise.
          if (sclk_fall && cnt_q > 5'd8) shadow_shift = 1'b1;
        end
      end
      S_DONE: if (cs_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_addr = {shift_q[5:0], mosi_s};
  assign wdata    = shift_q[15:0];

  // Read mux indexed by the address arriving with the 8th bit.
  always_comb begin
    rd_data = '0;
    case (cmd_addr)
      7'h00: rd_data = 16'(fcw_lo_q);
      7'h01: rd_data = 16'(fcw_hi_q);
      7'h02: rd_data = 16'(ctrl_q);
      7'h03: rd_data = 16'(cfg3_q);
      7'h04: rd_data = 16'(cfg4_q);
      7'h05: rd_data = 16'(cfg5_q);
      7'h06: rd_data = 16'(kdtcb_q);
      7'h07: rd_data = 16'(kdtcc_q);
      7'h08: rd_data = 16'(kdtcd_q);
      default: rd_data = '0;
    endcase
  end

  // Frame shifter, command latch, read shadow and write-pending strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q   <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      shadow_q  <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      if (shift_en) shift_q <= {shift_q[22:0], mosi_s};
      if (cmd_done) begin
        wr_q     <= shift_q[6];
        addr_q   <= cmd_addr;
        shadow_q <= rd_data;
      end else if (shadow_shift) begin
        shadow_q <= {shadow_q[14:0], 1'b0};
      end
      wr_pend_q <= frame_done & wr_q;
    end
  end

  // Register bank, written the cycle after the 24th bit shifts in.
  // NOTE: these are control flops carrying bring-up defaults, not a RAM, so
  // every one of them is reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fcw_lo_q <= FCW_LO_RST;
      fcw_hi_q <= FCW_HI_RST;
      fcw_q    <= {FCW_HI_RST, FCW_LO_RST};
      ctrl_q   <= 11'h189;
      cfg3_q   <= 13'h0100;
      cfg4_q   <= 14'h3C00;
      cfg5_q   <= 15'h6FA0;
      kdtcb_q  <= 10'h186;
      kdtcc_q  <= 10'h0C3;
      kdtcd_q  <= 10'h000;
    end else if (wr_pend_q) begin
      case (addr_q)
        7'h00: fcw_lo_q <= wdata[WF-1:0];
        7'h01: begin
          fcw_hi_q <= wdata[WI-1:0];
          fcw_q    <= {wdata[WI-1:0], fcw_lo_q};
        end
        7'h02: ctrl_q  <= wdata[10:0];
        7'h03: cfg3_q  <= wdata[12:0];
        7'h04: cfg4_q  <= wdata[13:0];
        7'h05: cfg5_q  <= wdata[14:0];
        7'h06: kdtcb_q <= wdata[9:0];
        7'h07: kdtcc_q <= wdata[9:0];
        7'h08: kdtcd_q <= wdata[9:0];
        default: ;
      endcase
    end
  end

  assign MISO    = (state_q == S_DATA && !wr_q) ? shadow_q[15] : 1'b0;
  assign FCW_FOD = fcw_q;
  assign {NARST, FREQ_HOP, NCO_SYNC_NRST_EN, DSM_SYNC_NRST_EN, SYS_EN, OFSTCALI_EN,
          DTCCALI_EN, RT_EN, FREQ_C_MODE, FREQ_C_EN, PCALI_EN} = ctrl_q;
  assign {PCALI_FREQDOWN, PCALI_KS, FREQ_C_KS} = cfg3_q;
  assign {CALIORDER, PSEG, PHASE_CTRL}         = cfg4_q;
  assign {KD, KC, KB}                          = cfg5_q;
  assign KDTCB_INIT = kdtcb_q;
  assign KDTCC_INIT = kdtcc_q;
  assign KDTCD_INIT = kdtcd_q;

endmodule
